// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction SRAM loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam int         SUM_W       = 32;
  localparam logic [3:0] WEB_ALL_OFF = 4'hF;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - instruction stream and SRAM wrapper port bundle
interface imem_loader_if #(
  parameter int ADDR_W = 14
) ();

  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              sram_cs;
  logic              sram_oe;
  logic [3:0]        sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [31:0]       sram_di;
  logic [31:0]       sram_do;

  // master is the loader; slave is the word source plus the SRAM
  modport master (
    input  in_valid, in_data, sram_do,
    output in_ready, sram_cs, sram_oe, sram_web, sram_a, sram_di
  );

  modport slave (
    output in_valid, in_data, sram_do,
    input  in_ready, sram_cs, sram_oe, sram_web, sram_a, sram_di
  );

endinterface

// File: rtl/imem_loader_checksum.sv
// rtl/imem_loader_checksum.sv - wrapping 32-bit accumulator with clear and add-enable
module loader_checksum
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_clr,
  input  logic             i_add,
  input  logic [SUM_W-1:0] i_data,
  output logic [SUM_W-1:0] o_sum,
  output logic [SUM_W-1:0] o_sum_next
);

  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum_add;

  assign w_sum_add = r_sum + i_data;

  // the look-ahead value lets the owner compare a sum that includes this cycle's add
  always_comb begin
    o_sum_next = r_sum;
    if (i_clr) begin
      o_sum_next = '0;
    end else if (i_add) begin
      o_sum_next = w_sum_add;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sum <= '0;
    end else begin
      r_sum <= o_sum_next;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction SRAM writer with optional readback checksum
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int BASE_WORD = 0,
  parameter bit VERIFY    = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [ADDR_W:0] len,
  imem_loader_if.master   bus,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            cpu_hold
);

  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_WORD);

  loader_state_e     r_state;
  loader_state_e     w_next;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_wcnt;
  logic [ADDR_W:0]   r_rcnt;
  logic              r_rd_vld;
  logic              r_done;
  logic              r_error;

  logic              w_start_ok;
  logic              w_wr_fire;
  logic              w_enter_done;
  logic [ADDR_W:0]   w_len_m1;
  logic [SUM_W-1:0]  w_wsum;
  logic [SUM_W-1:0]  w_wsum_next;
  logic [SUM_W-1:0]  w_rsum;
  logic [SUM_W-1:0]  w_rsum_next;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
  assign w_wr_fire  = (r_state == ST_WRITE) && bus.in_valid;
  assign w_len_m1   = r_len - 1'b1;

  loader_checksum u_wsum (
    .clk        (clk),
    .nrst       (nrst),
    .i_clr      (w_start_ok),
    .i_add      (w_wr_fire),
    .i_data     (bus.in_data),
    .o_sum      (w_wsum),
    .o_sum_next (w_wsum_next)
  );

  // sram_do is sampled one cycle after its address, hence r_rd_vld as the add-enable
  loader_checksum u_rsum (
    .clk        (clk),
    .nrst       (nrst),
    .i_clr      (w_start_ok),
    .i_add      (r_rd_vld),
    .i_data     (bus.sram_do),
    .o_sum      (w_rsum),
    .o_sum_next (w_rsum_next)
  );

  always_comb begin
    w_next       = r_state;
    w_enter_done = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (len == '0) begin
            w_next       = ST_DONE;
            w_enter_done = 1'b1;
          end else if (len > FULL_LEN) begin
            w_next = ST_ERR;
          end else begin
            w_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (w_wr_fire && r_wcnt == w_len_m1) begin
          if (VERIFY) begin
            w_next = ST_RD_ISSUE;
          end else begin
            w_next       = ST_DONE;
            w_enter_done = 1'b1;
          end
        end
      end
      ST_RD_ISSUE: begin
        if (r_rcnt == w_len_m1) begin
          w_next = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        // the last read word lands this cycle, so compare against the look-ahead sum
        if (w_rsum_next == w_wsum) begin
          w_next       = ST_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_next = ST_ERR;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_rcnt   <= '0;
      r_rd_vld <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done   <= w_enter_done;
      r_rd_vld <= (r_state == ST_RD_ISSUE);
      if (w_start_ok) begin
        r_len   <= len;
        r_wcnt  <= '0;
        r_rcnt  <= '0;
        r_error <= (w_next == ST_ERR);
      end else begin
        if (w_wr_fire) begin
          r_wcnt <= r_wcnt + 1'b1;
        end
        if (r_state == ST_RD_ISSUE) begin
          r_rcnt <= r_rcnt + 1'b1;
        end
        if (w_next == ST_ERR) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = (r_state == ST_WRITE);
    bus.sram_cs  = 1'b1;
    bus.sram_oe  = 1'b1;
    bus.sram_web = WEB_ALL_OFF;
    bus.sram_a   = '0;
    bus.sram_di  = '0;
    if (w_wr_fire) begin
      bus.sram_web = 4'h0;
      bus.sram_a   = BASE_A + r_wcnt[ADDR_W-1:0];
      bus.sram_di  = bus.in_data;
    end else if (r_state == ST_RD_ISSUE) begin
      bus.sram_a   = BASE_A + r_rcnt[ADDR_W-1:0];
    end
  end

  assign busy     = (r_state == ST_WRITE) || (r_state == ST_RD_ISSUE) || (r_state == ST_RD_DRAIN);
  assign done     = r_done;
  assign error    = r_error;
  assign cpu_hold = (r_state != ST_DONE);

endmodule
